// File: rtl/zion_rr_grant_sched.sv
// zion_rr_grant_sched: round-robin scheduler for one shared downstream resource.
// A grant is held until the resource signals done, the requester withdraws, or
// the hold timeout fires. On release the next winner is registered on the same
// edge, so back-to-back grants have no idle bubble.
module zion_rr_grant_sched #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] iReq,
  input  logic               iDone,
  output logic               oGntVld,
  output logic [IDX_W-1:0]   oGntIdx,
  output logic [NUM_REQ-1:0] oGnt,
  output logic               oTimeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last hold-counter value before a forced release (unused when MAX_HOLD == 0).
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  // Pointer reset value makes requester 0 the first in line.
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               tmo_reg, tmo_next;

  logic               active;
  logic               rel_done, rel_abort, rel_tmo, rel_any;
  logic [NUM_REQ-1:0] req_mask;
  logic [IDX_W-1:0]   search_base;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0] req_rot;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  int                 win_off;
  int                 win_pos;

  // Release decode: done beats withdrawal, withdrawal beats timeout.
  always_comb begin
    active    = (state_reg == GRANT);
    rel_done  = active && iDone;
    rel_abort = active && !iDone && !iReq[idx_reg];
    rel_tmo   = active && !iDone && iReq[idx_reg] && (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);
    rel_any   = rel_done || rel_abort || rel_tmo;
  end

  // Rotating priority search starting just after the last-served (or just-released) index.
  always_comb begin
    req_mask = iReq;
    if (rel_any) begin
      req_mask[idx_reg] = 1'b0;
    end
    search_base = rel_any ? idx_reg : ptr_reg;
    req_dbl     = {req_mask, req_mask} >> (int'(search_base) + 1);
    req_rot     = req_dbl[NUM_REQ-1:0];
    win_vld     = 1'b0;
    win_off     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_vld = 1'b1;
        win_off = i;
      end
    end
    win_pos = int'(search_base) + 1 + win_off;
    if (win_pos >= NUM_REQ) begin
      win_pos = win_pos - NUM_REQ;
    end
    win_idx = IDX_W'(win_pos);
  end

  // State register bank; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ptr_reg   <= PTR_RST;
      cnt_reg   <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
    end
  end

  // Next-state logic: grant from idle, hold/count, or release with same-edge regrant.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    tmo_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_vld) begin
          state_next = GRANT;
          idx_next   = win_idx;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (rel_any) begin
          ptr_next = idx_reg;
          tmo_next = rel_tmo;
          cnt_next = '0;
          if (win_vld) begin
            idx_next = win_idx;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt_reg != HOLD_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign oGntVld  = (state_reg == GRANT);
  assign oGntIdx  = idx_reg;
  assign oTimeout = tmo_reg;

  // One-hot grant is the decode of the index, gated by grant-valid.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign oGnt[gi] = oGntVld && (idx_reg == IDX_W'(gi));
  end

endmodule
